// File: rtl/sd_sec_arbiter_pkg.sv
// Shared constants and sequencer state encoding for the SD sector arbiter.
package sd_arb_pkg;

  localparam int unsigned BUSY_TIMEOUT = 1024;
  localparam int unsigned SECTOR_BYTES = 512;
  localparam int unsigned ADDR_W       = 32;
  localparam int unsigned NUM_CLIENTS  = 2;

  typedef enum logic [5:0] {
    ST_WAIT_INIT = 6'b000001,
    ST_IDLE      = 6'b000010,
    ST_START     = 6'b000100,
    ST_WAIT_HI   = 6'b001000,
    ST_WAIT_LO   = 6'b010000,
    ST_GAP       = 6'b100000
  } state_t;

endpackage

// File: rtl/sd_sec_arbiter_if.sv
// Client request/response and sector-engine handshake bundle for sd_sec_arbiter.
interface sd_sec_arbiter_if #(
  parameter int unsigned CNT_W = 16
);
  import sd_arb_pkg::*;

  logic                   sd_init_done;

  logic                   c0_req;
  logic                   c0_wr;
  logic [ADDR_W-1:0]      c0_addr;
  logic [CNT_W-1:0]       c0_cnt;
  logic                   c0_ack;
  logic                   c0_done;
  logic                   c0_err;

  logic                   c1_req;
  logic                   c1_wr;
  logic [ADDR_W-1:0]      c1_addr;
  logic [CNT_W-1:0]       c1_cnt;
  logic                   c1_ack;
  logic                   c1_done;
  logic                   c1_err;

  logic                   rd_start_en;
  logic [ADDR_W-1:0]      rd_sec_addr;
  logic                   rd_busy;
  logic                   wr_start_en;
  logic [ADDR_W-1:0]      wr_sec_addr;
  logic                   wr_busy;

  logic [NUM_CLIENTS-1:0] grant;

  // Arbiter side.
  modport master (
    input  sd_init_done,
    input  c0_req, c0_wr, c0_addr, c0_cnt,
    output c0_ack, c0_done, c0_err,
    input  c1_req, c1_wr, c1_addr, c1_cnt,
    output c1_ack, c1_done, c1_err,
    output rd_start_en, rd_sec_addr,
    input  rd_busy,
    output wr_start_en, wr_sec_addr,
    input  wr_busy,
    output grant
  );

  // Clients and engines.
  modport slave (
    output sd_init_done,
    output c0_req, c0_wr, c0_addr, c0_cnt,
    input  c0_ack, c0_done, c0_err,
    output c1_req, c1_wr, c1_addr, c1_cnt,
    input  c1_ack, c1_done, c1_err,
    input  rd_start_en, rd_sec_addr,
    output rd_busy,
    input  wr_start_en, wr_sec_addr,
    output wr_busy,
    input  grant
  );

endinterface

// File: rtl/sd_sec_arbiter_sel.sv
// Two-way request selector with one-hot grant.
// SD_ARB_RR_EN selects round-robin; otherwise client 0 has fixed priority.
module sd_arb_sel
  import sd_arb_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_CLIENTS-1:0] req,
  input  logic                   update,
  output logic [NUM_CLIENTS-1:0] gnt_c
);

`ifdef SD_ARB_RR_EN
  logic last;

  // Index of the last granted client; reset value lets client 0 win first.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last <= 1'b1;
    end else if (update && (|gnt_c)) begin
      last <= gnt_c[1];
    end
  end

  always_comb begin
    gnt_c = '0;
    if (req == 2'b11) begin
      gnt_c = last ? 2'b01 : 2'b10;
    end else begin
      gnt_c = req;
    end
  end
`else
  logic unused_rr;
  assign unused_rr = ^{clk, rst_n, update};

  always_comb begin
    gnt_c = '0;
    if (req[0]) begin
      gnt_c = 2'b01;
    end else if (req[1]) begin
      gnt_c = 2'b10;
    end
  end
`endif

endmodule

// File: rtl/sd_sec_arbiter.sv
// Shares one SD sector read/write engine between two clients, issuing one start
// pulse per sector with an idle gap. SD_ARB_RR_EN enables round-robin arbitration.
module sd_sec_arbiter
  import sd_arb_pkg::*;
#(
  parameter int unsigned GAP_CYCLES = 255,
  parameter int unsigned CNT_W      = 16
)(
  input  logic             clk,
  input  logic             rst_n,
  sd_sec_arbiter_if.master bus
);

  localparam int unsigned TMO_W = $clog2(BUSY_TIMEOUT);
  localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  state_t                 state;
  logic                   owner;
  logic                   cur_wr;
  logic [ADDR_W-1:0]      cur_addr;
  logic [CNT_W-1:0]       rem;
  logic [TMO_W-1:0]       tmo;
  logic [GAP_W-1:0]       gap_cnt;
  logic [NUM_CLIENTS-1:0] ack_q;
  logic [NUM_CLIENTS-1:0] done_q;
  logic [NUM_CLIENTS-1:0] err_q;
  logic [NUM_CLIENTS-1:0] grant_q;
  logic                   rd_start_q;
  logic                   wr_start_q;
  logic [ADDR_W-1:0]      rd_addr_q;
  logic [ADDR_W-1:0]      wr_addr_q;

  logic [NUM_CLIENTS-1:0] req_c;
  logic [NUM_CLIENTS-1:0] sel_c;
  logic [NUM_CLIENTS-1:0] own_c;
  logic                   accept_c;
  logic                   busy_c;
  logic                   last_c;

  assign req_c    = {bus.c1_req, bus.c0_req};
  assign accept_c = (state == ST_IDLE) && (|req_c);
  assign own_c    = owner ? 2'b10 : 2'b01;
  assign busy_c   = cur_wr ? bus.wr_busy : bus.rd_busy;
  assign last_c   = (rem == CNT_W'(1));

  sd_arb_sel u_sel (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req_c),
    .update (accept_c),
    .gnt_c  (sel_c)
  );

  // Sector sequencer; all client and engine outputs are registered here.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_WAIT_INIT;
      owner      <= 1'b0;
      cur_wr     <= 1'b0;
      cur_addr   <= '0;
      rem        <= '0;
      tmo        <= '0;
      gap_cnt    <= '0;
      ack_q      <= '0;
      done_q     <= '0;
      err_q      <= '0;
      grant_q    <= '0;
      rd_start_q <= 1'b0;
      wr_start_q <= 1'b0;
      rd_addr_q  <= '0;
      wr_addr_q  <= '0;
    end else begin
      ack_q      <= '0;
      done_q     <= '0;
      err_q      <= '0;
      rd_start_q <= 1'b0;
      wr_start_q <= 1'b0;
      case (state)
        ST_WAIT_INIT: begin
          if (bus.sd_init_done) begin
            state <= ST_IDLE;
          end
        end
        ST_IDLE: begin
          if (|sel_c) begin
            owner    <= sel_c[1];
            cur_wr   <= sel_c[1] ? bus.c1_wr   : bus.c0_wr;
            cur_addr <= sel_c[1] ? bus.c1_addr : bus.c0_addr;
            rem      <= sel_c[1] ? bus.c1_cnt  : bus.c0_cnt;
            ack_q    <= sel_c;
            grant_q  <= sel_c;
            state    <= ST_START;
          end
        end
        ST_START: begin
          // A zero-length request completes without touching the engine.
          if (rem == '0) begin
            done_q  <= own_c;
            grant_q <= '0;
            state   <= ST_IDLE;
          end else begin
            rd_start_q <= ~cur_wr;
            wr_start_q <= cur_wr;
            rd_addr_q  <= cur_wr ? '0 : cur_addr;
            wr_addr_q  <= cur_wr ? cur_addr : '0;
            tmo        <= '0;
            state      <= ST_WAIT_HI;
          end
        end
        ST_WAIT_HI: begin
          if (busy_c) begin
            state <= ST_WAIT_LO;
          end else if (tmo == TMO_W'(BUSY_TIMEOUT - 1)) begin
            done_q  <= own_c;
            err_q   <= own_c;
            grant_q <= '0;
            state   <= ST_IDLE;
          end else begin
            tmo <= tmo + TMO_W'(1);
          end
        end
        ST_WAIT_LO: begin
          if (!busy_c) begin
            cur_addr <= cur_addr + ADDR_W'(1);
            rem      <= rem - CNT_W'(1);
            if (last_c) begin
              done_q  <= own_c;
              grant_q <= '0;
              state   <= ST_IDLE;
            end else if (GAP_CYCLES > 1) begin
              gap_cnt <= GAP_W'(1);
              state   <= ST_GAP;
            end else if (!bus.sd_init_done) begin
              done_q  <= own_c;
              err_q   <= own_c;
              grant_q <= '0;
              state   <= ST_WAIT_INIT;
            end else begin
              state <= ST_START;
            end
          end
        end
        ST_GAP: begin
          // Card loss is only acted on at a sector boundary.
          if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
            if (!bus.sd_init_done) begin
              done_q  <= own_c;
              err_q   <= own_c;
              grant_q <= '0;
              state   <= ST_WAIT_INIT;
            end else begin
              state <= ST_START;
            end
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
        default: begin
          state <= ST_WAIT_INIT;
        end
      endcase
    end
  end

  assign bus.c0_ack      = ack_q[0];
  assign bus.c1_ack      = ack_q[1];
  assign bus.c0_done     = done_q[0];
  assign bus.c1_done     = done_q[1];
  assign bus.c0_err      = err_q[0];
  assign bus.c1_err      = err_q[1];
  assign bus.rd_start_en = rd_start_q;
  assign bus.wr_start_en = wr_start_q;
  assign bus.rd_sec_addr = rd_addr_q;
  assign bus.wr_sec_addr = wr_addr_q;
  assign bus.grant       = grant_q;

endmodule
